// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit ripple-carry adder: one SW-bit carry slice per stage, valid/ready handshake
// with whole-pipeline backpressure. Operand upper slices and lower sum slices are skewed in regs.
module adder_pipe_nbit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0]            valid_q, carry_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic                         overflow_q;

  // Per-stage inputs and slice results
  logic [STAGES-1:0]            stage_vld, stage_cin, stage_cout, msb_cin;
  logic [STAGES-1:0][WIDTH-1:0] stage_a, stage_b, stage_sin, stage_sum;

  logic adv;

  assign adv      = out_ready | ~valid_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    stage_vld = '0;
    stage_cin = '0;
    stage_a   = '0;
    stage_b   = '0;
    stage_sin = '0;
    stage_vld[0] = in_valid;
    stage_a[0]   = a;
    stage_b[0]   = b;
    stage_cin[0] = carry_in;
    for (int k = 1; k < STAGES; k++) begin
      stage_vld[k] = valid_q[k-1];
      stage_a[k]   = a_q[k-1];
      stage_b[k]   = b_q[k-1];
      stage_cin[k] = carry_q[k-1];
      stage_sin[k] = sum_q[k-1];
    end
  end

  always_comb begin : ripple
    logic c;
    c          = 1'b0;
    stage_sum  = stage_sin;
    stage_cout = '0;
    msb_cin    = '0;
    for (int k = 0; k < STAGES; k++) begin
      c = stage_cin[k];
      for (int i = 0; i < SW; i++) begin
        // Carry into the slice MSB; only the last stage's value feeds overflow
        if (i == SW - 1) msb_cin[k] = c;
        stage_sum[k][k*SW+i] = stage_a[k][k*SW+i] ^ stage_b[k][k*SW+i] ^ c;
        c = (stage_a[k][k*SW+i] & stage_b[k][k*SW+i]) |
            (c & (stage_a[k][k*SW+i] ^ stage_b[k][k*SW+i]));
      end
      stage_cout[k] = c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      carry_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else if (adv) begin
      valid_q <= stage_vld;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= stage_a[k];
        b_q[k] <= stage_b[k];
        // Output stage keeps its last result across bubbles
        if (k < int'(STAGES) - 1 || stage_vld[k]) begin
          sum_q[k]   <= stage_sum[k];
          carry_q[k] <= stage_cout[k];
        end
      end
      if (stage_vld[STAGES-1]) begin
        overflow_q <= msb_cin[STAGES-1] ^ stage_cout[STAGES-1];
      end
    end
  end

  // Operands are fully consumed by the last stage; its skew copy has no reader
  logic unused_skew;
  assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry_out = carry_q[STAGES-1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: three configurations run side by side against a queue-based model
// that tracks each accepted transaction's advance count instead of a register pipeline.
module tb_adder_pipe_nbit;

  localparam int NC = 3;
  localparam int W_CFG [NC] = '{16, 16, 8};
  localparam int S_CFG [NC] = '{4, 1, 8};
  localparam int QD = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_in   [NC];
  logic [15:0] b_in   [NC];
  logic        cin_in [NC];
  logic        iv_in  [NC];
  logic        ordy_in[NC];
  logic [15:0] sum_o  [NC];
  logic        co_o   [NC];
  logic        of_o   [NC];
  logic        ov_o   [NC];
  logic        ir_o   [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int W = W_CFG[g];
    localparam int S = S_CFG[g];
    logic [W-1:0] s;
    adder_pipe_nbit #(
      .WIDTH (W),
      .STAGES(S)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv_in[g]),
      .in_ready (ir_o[g]),
      .a        (a_in[g][W-1:0]),
      .b        (b_in[g][W-1:0]),
      .carry_in (cin_in[g]),
      .out_valid(ov_o[g]),
      .out_ready(ordy_in[g]),
      .sum      (s),
      .carry_out(co_o[g]),
      .overflow (of_o[g])
    );
    assign sum_o[g] = 16'(s);
  end

  int checks = 0;
  int errors = 0;

  // Model: in-order queue of expected results plus the global advance count at acceptance
  logic [15:0] q_sum[NC][QD];
  logic        q_co [NC][QD];
  logic        q_of [NC][QD];
  int          q_acc[NC][QD];
  int          wr[NC], rd[NC], adv_total[NC];

  function automatic void chk(input string name, input int g, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cfg%0d got %0h want %0h at %0t", name, g, got, want, $time);
    end
  endfunction

  function automatic void calc(input int w, input logic [15:0] x, input logic [15:0] y,
                               input logic c, output logic [15:0] s, output logic co,
                               output logic of);
    logic [16:0] full, mask;
    mask = (17'd1 << w) - 17'd1;
    full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + 17'(c);
    co   = full[w];
    s    = full[15:0] & mask[15:0];
    of   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  function automatic logic model_valid(input int g);
    if (rd[g] == wr[g]) return 1'b0;
    return (adv_total[g] - q_acc[g][rd[g] % QD]) >= S_CFG[g] - 1;
  endfunction

  // Called just after a falling edge with inputs already driven
  task automatic step();
    logic ov_m, adv, co, of;
    logic [15:0] s;
    int h;
    #1;
    for (int g = 0; g < NC; g++) begin
      ov_m = model_valid(g);
      adv  = ordy_in[g] || !ov_m;
      chk("in_ready", g, 32'(ir_o[g]), 32'(adv));
      if (adv) adv_total[g]++;
      if (ov_m && ordy_in[g]) rd[g]++;
      if (iv_in[g] && adv) begin
        h = wr[g] % QD;
        calc(W_CFG[g], a_in[g], b_in[g], cin_in[g], s, co, of);
        q_sum[g][h] = s;
        q_co[g][h]  = co;
        q_of[g][h]  = of;
        q_acc[g][h] = adv_total[g];
        wr[g]++;
      end
    end
    @(negedge clk);
    for (int g = 0; g < NC; g++) begin
      ov_m = model_valid(g);
      chk("out_valid", g, 32'(ov_o[g]), 32'(ov_m));
      if (ov_m) begin
        h = rd[g] % QD;
        chk("sum", g, 32'(sum_o[g]), 32'(q_sum[g][h]));
        chk("carry_out", g, 32'(co_o[g]), 32'(q_co[g][h]));
        chk("overflow", g, 32'(of_o[g]), 32'(q_of[g][h]));
      end
    end
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic r);
    for (int g = 0; g < NC; g++) begin
      iv_in[g]   = v;
      ordy_in[g] = r;
      a_in[g]    = rand_op();
      b_in[g]    = rand_op();
      cin_in[g]  = 1'($urandom);
    end
  endtask

  task automatic reset_checks();
    for (int g = 0; g < NC; g++) begin
      chk("rst_out_valid", g, 32'(ov_o[g]), 32'd0);
      chk("rst_sum", g, 32'(sum_o[g]), 32'd0);
      chk("rst_carry_out", g, 32'(co_o[g]), 32'd0);
      chk("rst_overflow", g, 32'(of_o[g]), 32'd0);
      chk("rst_in_ready", g, 32'(ir_o[g]), 32'd1);
    end
  endtask

  // Directed vectors; the 8-bit config sees only the low byte of each operand
  logic [15:0] dv_a  [4] = '{16'h7FFF, 16'hFFFF, 16'h00FF, 16'h007F};
  logic [15:0] dv_b  [4] = '{16'h0001, 16'h0000, 16'h0F01, 16'h0001};
  logic        dv_c  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] e16_s [4] = '{16'h8000, 16'h0000, 16'h1000, 16'h0080};
  logic        e16_co[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        e16_of[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] e8_s  [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0080};
  logic        e8_co [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic        e8_of [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] s;
    logic co, of;

    // Pin the reference arithmetic itself
    calc(16, 16'h7FFF, 16'h0001, 1'b0, s, co, of);
    chk("model_ovf", 0, {s, 14'd0, co, of}, {16'h8000, 14'd0, 1'b0, 1'b1});
    calc(16, 16'hFFFF, 16'h0000, 1'b1, s, co, of);
    chk("model_wrap", 0, {s, 14'd0, co, of}, {16'h0000, 14'd0, 1'b1, 1'b0});
    calc(16, 16'h00FF, 16'h0F01, 1'b0, s, co, of);
    chk("model_xslice", 0, {s, 14'd0, co, of}, {16'h1000, 14'd0, 1'b0, 1'b0});

    for (int g = 0; g < NC; g++) begin
      wr[g] = 0;
      rd[g] = 0;
      adv_total[g] = 0;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0);
    #2;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1);
    step();

    // Directed vectors, one at a time, with literal latency and result checks
    for (int v = 0; v < 4; v++) begin
      for (int g = 0; g < NC; g++) begin
        iv_in[g]  = 1'b1;
        a_in[g]   = dv_a[v];
        b_in[g]   = dv_b[v];
        cin_in[g] = dv_c[v];
      end
      step();
      for (int g = 0; g < NC; g++) iv_in[g] = 1'b0;
      for (int n = 0; n < 9; n++) begin
        for (int g = 0; g < NC; g++) begin
          chk("lat_valid", g, 32'(ov_o[g]), 32'(n == S_CFG[g] - 1));
          if (n == S_CFG[g] - 1) begin
            chk("dir_sum", g, 32'(sum_o[g]), 32'(W_CFG[g] == 16 ? e16_s[v] : e8_s[v]));
            chk("dir_co", g, 32'(co_o[g]), 32'(W_CFG[g] == 16 ? e16_co[v] : e8_co[v]));
            chk("dir_of", g, 32'(of_o[g]), 32'(W_CFG[g] == 16 ? e16_of[v] : e8_of[v]));
          end
        end
        step();
      end
    end

    // Streaming: 8 back-to-back, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1);
      step();
    end

    // Backpressure: 6 in, 3-cycle stall with changing inputs, release
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      step();
    end

    // Bubbles: alternating in_valid
    for (int i = 0; i < 16; i++) begin
      drive(1'(i % 2 == 0), 1'b1);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1);
      step();
    end

    // Random valid/ready mix
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      step();
    end

    // Mid-stream reset with transactions in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      step();
    end
    drive(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    for (int g = 0; g < NC; g++) rd[g] = wr[g];
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
